// File: rtl/melody_recorder.sv
// Live melody capture: quantises key holds into 6-bit player note codes and writes them to the melody store.
// Optional feature macro: MELODY_REC_REST_EN (writes one rest code 0 per long silent gap).
module melody_recorder #(
    parameter int DEPTH       = 64,
    parameter int ADDR_W      = 6,
    parameter int UNIT_CYCLES = 12_500_000,
    parameter int REST_UNITS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rec_en,
    input  logic [6:0]        keys,
    input  logic              isHight,
    input  logic              isLow,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [5:0]        wr_code,
    output logic [ADDR_W:0]   rec_length,
    output logic              full,
    output logic              recording
);

    localparam int HOLD_MAX = 4 * UNIT_CYCLES;
    localparam int H_W      = $clog2(HOLD_MAX + 1);
    localparam logic [H_W-1:0]    HOLD_SAT   = H_W'(HOLD_MAX);
    localparam logic [H_W-1:0]    SIXT_LIM   = H_W'(2 * UNIT_CYCLES);
    localparam logic [H_W-1:0]    EIGHTH_LIM = H_W'(4 * UNIT_CYCLES);
    localparam logic [ADDR_W:0]   DEPTH_C    = (ADDR_W + 1)'(DEPTH);
`ifdef MELODY_REC_REST_EN
    localparam int REST_MAX = REST_UNITS * UNIT_CYCLES;
    localparam int G_W      = $clog2(REST_MAX + 1);
    localparam logic [G_W-1:0] GAP_SAT = G_W'(REST_MAX);
`endif

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2} state_t;
    typedef enum logic [1:0] {OCT_MID = 2'd0, OCT_LOW = 2'd1, OCT_HIGH = 2'd2} oct_t;
    typedef enum logic [1:0] {DUR_EIGHTH = 2'd0, DUR_QUARTER = 2'd1, DUR_SIXTEENTH = 2'd2} dur_t;

    // Highest pressed key wins; do (bit 6) maps to note 0.
    function automatic logic [2:0] note_index(input logic [6:0] k);
        logic [2:0] idx;
        if (k[6])      idx = 3'd0;
        else if (k[5]) idx = 3'd1;
        else if (k[4]) idx = 3'd2;
        else if (k[3]) idx = 3'd3;
        else if (k[2]) idx = 3'd4;
        else if (k[1]) idx = 3'd5;
        else           idx = 3'd6;
        return idx;
    endfunction

    function automatic oct_t octave_sel(input logic hi, input logic lo);
        oct_t o;
        if (hi && !lo)      o = OCT_HIGH;
        else if (lo && !hi) o = OCT_LOW;
        else                o = OCT_MID;
        return o;
    endfunction

    function automatic dur_t dur_class(input logic [H_W-1:0] h);
        dur_t d;
        if (h < SIXT_LIM)        d = DUR_SIXTEENTH;
        else if (h < EIGHTH_LIM) d = DUR_EIGHTH;
        else                     d = DUR_QUARTER;
        return d;
    endfunction

    // Bases step by 21 per octave band and by 7 per duration class, starting at mid eighth = 1.
    function automatic logic [5:0] note_code(input oct_t o, input dur_t d, input logic [2:0] n);
        logic [5:0] base;
        case (o)
            OCT_LOW:  base = 6'd22;
            OCT_HIGH: base = 6'd43;
            default:  base = 6'd1;
        endcase
        case (d)
            DUR_QUARTER:   base = base + 6'd7;
            DUR_SIXTEENTH: base = base + 6'd14;
            default:       base = base + 6'd0;
        endcase
        return base + {3'd0, n};
    endfunction

    logic [6:0]        keys_q;
    logic              hi_q, lo_q;
    state_t            state_q, state_d;
    logic [2:0]        note_q, note_d;
    oct_t              oct_q, oct_d;
    logic [H_W-1:0]    hold_q, hold_d;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   rec_length_q;
    logic              full_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [5:0]        wr_code_q;
    logic              recording_q;
`ifdef MELODY_REC_REST_EN
    logic [G_W-1:0]    gap_q, gap_d;
`endif

    logic              smp_valid_s;
    logic [2:0]        smp_note_s;
    oct_t              smp_oct_s;
    logic              wr_req_s;
    logic              wr_fire_s;
    logic              clear_take_s;
    logic [5:0]        wr_code_s;

    assign smp_valid_s = |keys_q;
    assign smp_note_s  = note_index(keys_q);
    assign smp_oct_s   = octave_sel(hi_q, lo_q);
    assign wr_fire_s   = wr_req_s && (count_q != DEPTH_C);

    // Input sample register; the FSM only ever looks at these values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            keys_q <= 7'd0;
            hi_q   <= 1'b0;
            lo_q   <= 1'b0;
        end else begin
            keys_q <= keys;
            hi_q   <= isHight;
            lo_q   <= isLow;
        end
    end

    // Next-state and write-request logic of the capture FSM.
    always_comb begin
        state_d      = state_q;
        note_d       = note_q;
        oct_d        = oct_q;
        hold_d       = hold_q;
        wr_req_s     = 1'b0;
        wr_code_s    = 6'd0;
        clear_take_s = 1'b0;
`ifdef MELODY_REC_REST_EN
        gap_d        = gap_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rec_en) begin
                    clear_take_s = 1'b1;
                    state_d      = S_WAIT;
`ifdef MELODY_REC_REST_EN
                    gap_d        = {G_W{1'b0}};
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!rec_en) begin
                    state_d = S_IDLE;
                end else if (smp_valid_s) begin
                    state_d = S_HOLD;
                    note_d  = smp_note_s;
                    oct_d   = smp_oct_s;
                    hold_d  = H_W'(1);
                end else begin
`ifdef MELODY_REC_REST_EN
                    // Saturating at the limit is what keeps it to a single rest per gap.
                    if (gap_q != GAP_SAT) begin
                        gap_d = gap_q + G_W'(1);
                        if ((gap_d == GAP_SAT) && (count_q != {(ADDR_W + 1){1'b0}})) begin
                            wr_req_s  = 1'b1;
                            wr_code_s = 6'd0;
                        end else begin
                            wr_req_s  = 1'b0;
                        end
                    end else begin
                        gap_d = gap_q;
                    end
`else
                    state_d = S_WAIT;
`endif
                end
            end
            S_HOLD: begin
                wr_code_s = note_code(oct_q, dur_class(hold_q), note_q);
                if (!rec_en) begin
                    wr_req_s = 1'b1;
                    state_d  = S_IDLE;
                end else if (!smp_valid_s) begin
                    wr_req_s = 1'b1;
                    state_d  = S_WAIT;
`ifdef MELODY_REC_REST_EN
                    gap_d    = {G_W{1'b0}};
`endif
                end else if (smp_note_s != note_q) begin
                    wr_req_s = 1'b1;
                    note_d   = smp_note_s;
                    oct_d    = smp_oct_s;
                    hold_d   = H_W'(1);
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + H_W'(1);
                end else begin
                    hold_d = hold_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state and latched note context.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            note_q  <= 3'd0;
            oct_q   <= OCT_MID;
            hold_q  <= {H_W{1'b0}};
`ifdef MELODY_REC_REST_EN
            gap_q   <= {G_W{1'b0}};
`endif
        end else begin
            state_q <= state_d;
            note_q  <= note_d;
            oct_q   <= oct_d;
            hold_q  <= hold_d;
`ifdef MELODY_REC_REST_EN
            gap_q   <= gap_d;
`endif
        end
    end

    // Write port, take length and full flag; rec_length trails the internal write pointer by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_q      <= 1'b0;
            wr_addr_q    <= {ADDR_W{1'b0}};
            wr_code_q    <= 6'd0;
            count_q      <= {(ADDR_W + 1){1'b0}};
            rec_length_q <= {(ADDR_W + 1){1'b0}};
            full_q       <= 1'b0;
            recording_q  <= 1'b0;
        end else begin
            wr_en_q     <= wr_fire_s;
            recording_q <= (state_d != S_IDLE);
            if (wr_fire_s) begin
                wr_addr_q <= count_q[ADDR_W-1:0];
                wr_code_q <= wr_code_s;
            end
            if (clear_take_s) begin
                count_q      <= {(ADDR_W + 1){1'b0}};
                rec_length_q <= {(ADDR_W + 1){1'b0}};
                full_q       <= 1'b0;
            end else begin
                count_q      <= wr_fire_s ? (count_q + (ADDR_W + 1)'(1)) : count_q;
                rec_length_q <= count_q;
                full_q       <= (count_q == DEPTH_C);
            end
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_code    = wr_code_q;
    assign rec_length = rec_length_q;
    assign full       = full_q;
    assign recording  = recording_q;

endmodule

// File: tb/tb_melody_recorder.sv
// Randomised bench for melody_recorder, checked every cycle against a note-level reference model.
module tb_melody_recorder;

    localparam int UNIT   = 4;
    localparam int DEPTH  = 4;
    localparam int RESTU  = 4;
    localparam int ADDR_W = 2;
    localparam int HMAX   = 4 * UNIT;
    localparam int RESTC  = RESTU * UNIT;

    logic              clk = 1'b0;
    logic              reset;
    logic              rec_en;
    logic [6:0]        keys;
    logic              isHight;
    logic              isLow;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [5:0]        wr_code;
    logic [ADDR_W:0]   rec_length;
    logic              full;
    logic              recording;

    always #5 clk = ~clk;

    melody_recorder #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .UNIT_CYCLES(UNIT), .REST_UNITS(RESTU)
    ) dut (
        .clk(clk), .reset(reset), .rec_en(rec_en), .keys(keys),
        .isHight(isHight), .isLow(isLow), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_code(wr_code), .rec_length(rec_length), .full(full), .recording(recording)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Code table indexed [octave: mid, low, high][duration: eighth, quarter, sixteenth].
    int base_tab [3][3] = '{'{1, 8, 15}, '{22, 29, 36}, '{43, 50, 57}};

    // Reference model: a take is on or off, a note is either sounding (index, octave, hold) or not.
    bit m_on;
    int m_note, m_oct, m_h, m_gap, m_count, m_len;
    bit m_full;
    int s_note, s_oct;
    bit e_wr;
    int e_addr, e_code;
    int obs_code[$];
    int obs_addr[$];

    function automatic int note_of(input logic [6:0] k);
        for (int b = 6; b >= 0; b--) if (k[b]) return 6 - b;
        return -1;
    endfunction

    function automatic int oct_of(input logic hi, input logic lo);
        if (hi && !lo) return 2;
        if (lo && !hi) return 1;
        return 0;
    endfunction

    function automatic int dur_of(input int h);
        if (h < 2 * UNIT) return 2;
        if (h < 4 * UNIT) return 0;
        return 1;
    endfunction

    function automatic int obs_at(input int i);
        if (i < obs_code.size()) return obs_code[i];
        return -1;
    endfunction

    task automatic m_write(input int c);
        if (m_count < DEPTH) begin
            e_wr   = 1'b1;
            e_addr = m_count;
            e_code = c;
            m_count++;
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_note = -1; m_oct = 0; m_h = 0; m_gap = 0;
        m_count = 0; m_len = 0; m_full = 0;
        s_note = -1; s_oct = 0; e_wr = 0; e_addr = 0; e_code = 0;
    endtask

    task automatic model_step();
        int new_len;
        bit new_full;
        new_len  = m_count;
        new_full = (m_count == DEPTH);
        e_wr     = 1'b0;
        if (!m_on) begin
            if (rec_en) begin
                m_on = 1; m_count = 0; new_len = 0; new_full = 0; m_gap = 0;
            end
        end else if (m_note < 0) begin
            if (!rec_en) m_on = 0;
            else if (s_note >= 0) begin
                m_note = s_note; m_oct = s_oct; m_h = 1;
            end else begin
`ifdef MELODY_REC_REST_EN
                if (m_gap < RESTC) begin
                    m_gap++;
                    if (m_gap == RESTC && m_count > 0) m_write(0);
                end
`endif
            end
        end else begin
            int c;
            c = base_tab[m_oct][dur_of(m_h)] + m_note;
            if (!rec_en) begin
                m_write(c); m_on = 0; m_note = -1;
            end else if (s_note < 0) begin
                m_write(c); m_note = -1; m_gap = 0;
            end else if (s_note != m_note) begin
                m_write(c); m_note = s_note; m_oct = s_oct; m_h = 1;
            end else if (m_h < HMAX) begin
                m_h++;
            end
        end
        m_len  = new_len;
        m_full = new_full;
        s_note = note_of(keys);
        s_oct  = oct_of(isHight, isLow);
    endtask

    task automatic compare();
        check_eq("wr_en", int'(wr_en), int'(e_wr));
        if (e_wr) begin
            check_eq("wr_addr", int'(wr_addr), e_addr);
            check_eq("wr_code", int'(wr_code), e_code);
        end
        check_eq("rec_length", int'(rec_length), m_len);
        check_eq("full", int'(full), int'(m_full));
        check_eq("recording", int'(recording), int'(m_on));
        if (wr_en) begin
            obs_code.push_back(int'(wr_code));
            obs_addr.push_back(int'(wr_addr));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_reset();
        else model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic play(input logic [6:0] k, input logic hi, input logic lo, input int n);
        keys = k; isHight = hi; isLow = lo;
        repeat (n) tick();
        keys = 7'd0; isHight = 1'b0; isLow = 1'b0;
    endtask

    task automatic new_take();
        rec_en = 1'b0;
        repeat (2) tick();
        rec_en = 1'b1;
        repeat (2) tick();
        obs_code.delete();
        obs_addr.delete();
    endtask

    initial begin
        reset = 1'b0; rec_en = 1'b0; keys = 7'd0; isHight = 1'b0; isLow = 1'b0;
        model_reset();
        #2;
        check_eq("rst_wr_en", int'(wr_en), 0);
        check_eq("rst_wr_addr", int'(wr_addr), 0);
        check_eq("rst_wr_code", int'(wr_code), 0);
        check_eq("rst_rec_length", int'(rec_length), 0);
        check_eq("rst_full", int'(full), 0);
        check_eq("rst_recording", int'(recording), 0);
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // Four notes fill the store; the fifth must not be written.
        new_take();
        play(7'b1000000, 1'b0, 1'b0, 10); repeat (3) tick();
        check_eq("mid_do_code", obs_at(0), 1);
        check_eq("mid_do_len", int'(rec_length), 1);
        play(7'b0000100, 1'b1, 1'b0, 20); repeat (3) tick();
        check_eq("high_sol_code", obs_at(1), 54);
        play(7'b0000010, 1'b0, 1'b1, 3); repeat (3) tick();
        check_eq("low_la_code", obs_at(2), 41);
        play(7'b0100000, 1'b1, 1'b1, 5); repeat (3) tick();
        check_eq("both_re_code", obs_at(3), 16);
        check_eq("full_set", int'(full), 1);
        check_eq("full_len", int'(rec_length), DEPTH);
        play(7'b0010000, 1'b0, 1'b0, 4); repeat (3) tick();
        check_eq("full_no_write", obs_code.size(), 4);
        new_take();
        check_eq("take_clear_full", int'(full), 0);
        check_eq("take_clear_len", int'(rec_length), 0);

        // Chord: do wins, then mi alone after do lifts; back-to-back writes.
        keys = 7'b1010000; repeat (9) tick();
        keys = 7'b0010000; repeat (2) tick();
        keys = 7'd0; repeat (3) tick();
        check_eq("chord_first", obs_at(0), 1);
        check_eq("chord_second", obs_at(1), 17);

        // Long silence after one note.
        new_take();
        play(7'b1000000, 1'b0, 1'b0, 3);
        repeat (40) tick();
`ifdef MELODY_REC_REST_EN
        check_eq("rest_count", obs_code.size(), 2);
        check_eq("rest_code", obs_at(1), 0);
        if (obs_addr.size() > 1) check_eq("rest_addr", obs_addr[1], 1);
        else check_eq("rest_addr", -1, 1);
`else
        check_eq("no_rest_count", obs_code.size(), 1);
`endif

        // rec_en dropped while holding fa (h=5, sixteenth) writes the note.
        new_take();
        keys = 7'b0001000; repeat (5) tick();
        rec_en = 1'b0; tick();
        check_eq("drop_code", obs_at(0), 18);
        keys = 7'd0; repeat (2) tick();
        check_eq("drop_recording", int'(recording), 0);

        // Reset while holding si discards the note.
        rec_en = 1'b1; repeat (2) tick();
        keys = 7'b0000001; repeat (5) tick();
        obs_code.delete(); obs_addr.delete();
        reset = 1'b0;
        #1;
        check_eq("midrst_wr_en", int'(wr_en), 0);
        check_eq("midrst_len", int'(rec_length), 0);
        check_eq("midrst_recording", int'(recording), 0);
        repeat (2) tick();
        reset = 1'b1; keys = 7'd0;
        repeat (5) tick();
        check_eq("midrst_no_write", obs_code.size(), 0);

        // Random play with occasional take restarts and long gaps.
        for (int s = 0; s < 160; s++) begin
            int r;
            int kc;
            r  = $urandom_range(0, 19);
            kc = $urandom_range(0, 9);
            if (r == 0) begin
                rec_en = 1'b0; keys = 7'd0;
                repeat ($urandom_range(1, 3)) tick();
                rec_en = 1'b1;
            end else if (r < 3) begin
                keys = 7'd0;
                repeat ($urandom_range(10, 40)) tick();
            end else begin
                if (kc < 3) keys = 7'd0;
                else if (kc < 9) keys = 7'(1 << $urandom_range(0, 6));
                else keys = 7'($urandom_range(0, 127));
                isHight = 1'($urandom_range(0, 1));
                isLow   = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 22)) tick();
            end
        end
        keys = 7'd0;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
